// File: rtl/core_pipe_pkg.sv
// Stage payload layouts shared by the core pipeline registers, with their idle (reset) values.
package core_pipe_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [11:0] csr_addr;
        logic [4:0]  exc_cause;
        logic        exc_valid;
        logic [11:0] rob_tag;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] pc;
        logic [31:0] wb_data;
    } mem_wb_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Idle payloads: every field zero, so valid=0 and no write-back side effects.
    localparam ex_mem_t EX_MEM_RESET = '0;
    localparam mem_wb_t MEM_WB_RESET = '0;

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module pipe_buf_mem #(
    parameter int               WIDTH      = 170,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_DATA;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: circular buffer whose upstream ready never looks at downstream ready.
module pipe_elastic_stage
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH      = EX_MEM_W,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ls_valid,
    output logic                       ts_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       ts_valid,
    input  logic                       ns_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    input  logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              LW       = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;
    logic [WIDTH-1:0] head_data;

    // Pointers alone cannot tell full from empty, so level carries that distinction.
    // ts_ready is gated by rst so it stays low while reset is held.
    assign ts_ready = rst && !stall && (level_q != FULL_LVL);
    assign ts_valid = !stall && (level_q != '0) && !flush;
    assign push     = ls_valid && ts_ready && !flush;
    assign pop      = ts_valid && ns_ready;
    assign level    = level_q;
    assign out_data = (level_q != '0) ? head_data : RESET_DATA;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    pipe_buf_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (RESET_DATA)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (level_q == FULL_LVL)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (level_q == '0)));
    a_level_range: assert property (@(posedge clk) disable iff (!rst)
        level_q <= FULL_LVL);

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: directed scenarios then constrained-random traffic vs a queue model.
module tb_pipe_elastic_stage;

    localparam int W     = 170;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam logic [W-1:0] RST_D = W'(128'h5A5A_0000_FFFF_1234_0F0F_A5A5_C3C3_9999);

    logic          clk = 1'b0;
    logic          rst;
    logic          ls_valid;
    logic          ts_ready;
    logic [W-1:0]  in_data;
    logic          ts_valid;
    logic          ns_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic          stall;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           model_level = 0;
    bit           run = 1'b0;
    bit           pend = 1'b0;
    logic [W-1:0] pend_d;

    pipe_elastic_stage #(
        .WIDTH      (W),
        .DEPTH      (DEPTH),
        .RESET_DATA (RST_D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ls_valid (ls_valid),
        .ts_ready (ts_ready),
        .in_data  (in_data),
        .ts_valid (ts_valid),
        .ns_ready (ns_ready),
        .out_data (out_data),
        .flush    (flush),
        .stall    (stall),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Drive one cycle of inputs, then at the edge record what the stage should have accepted.
    task automatic step(bit lv, logic [W-1:0] d, bit nr, bit fl, bit st);
        bit acc, rel;
        ls_valid = lv; in_data = d; ns_ready = nr; flush = fl; stall = st;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            model_level = 0;
            pend = 1'b0;
        end else begin
            acc = ls_valid && !stall && (model_level < DEPTH);
            rel = !stall && (model_level != 0) && ns_ready;
            if (acc) exp_q.push_back(in_data);
            model_level += int'(acc) - int'(rel);
            pend   = ls_valid && !acc;
            pend_d = in_data;
        end
        #1;
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_ts_valid"}, W'(ts_valid), W'(0));
        chk({tag, "_ts_ready"}, W'(ts_ready), W'(0));
        chk({tag, "_level"},    W'(level),    W'(0));
        chk({tag, "_out_data"}, out_data,     RST_D);
    endtask

    task automatic do_reset();
        ls_valid = 1'b1; in_data = rnd(); ns_ready = 1'b1; flush = 1'b0; stall = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("midreset");
        exp_q.delete();
        model_level = 0;
        pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compares handshakes and head payload against the model every cycle.
    always @(negedge clk) begin
        bit ev, er;
        if (rst && run) begin
            er = !stall && (model_level < DEPTH);
            ev = !stall && (model_level != 0) && !flush;
            chk("ts_ready", W'(ts_ready), W'(er));
            chk("ts_valid", W'(ts_valid), W'(ev));
            chk("level",    W'(level),    W'(model_level));
            if (model_level != 0 && exp_q.size() != 0)
                chk("head", out_data, exp_q[0]);
            else
                chk("empty_out", out_data, RST_D);
            if (ev && ns_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow actual=pop required=no_entry t=%0t", $time);
                end else begin
                    chk("pop_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        ls_valid = 1'b1; in_data = rnd(); ns_ready = 1'b1; flush = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        run = 1'b1;

        // Streaming: one-cycle latency, level stays at 1.
        step(1, W'(1), 1, 0, 0);
        step(1, W'(2), 1, 0, 0);
        step(1, W'(3), 1, 0, 0);
        step(0, '0,    1, 0, 0);
        step(0, '0,    1, 0, 0);

        // Backpressure to full, then push+pop against a full buffer.
        step(1, W'('hA), 0, 0, 0);
        step(1, W'('hB), 0, 0, 0);
        step(1, W'('hD), 0, 0, 0);
        step(1, W'('hD), 1, 0, 0);
        step(1, W'('hD), 1, 0, 0);
        step(0, '0,      1, 0, 0);
        step(0, '0,      1, 0, 0);
        step(0, '0,      1, 0, 0);

        // Flush with full buffer and a same-cycle incoming payload.
        step(1, W'('hA), 0, 0, 0);
        step(1, W'('hB), 0, 0, 0);
        step(1, W'('hC), 1, 1, 0);
        step(0, '0,      1, 0, 0);
        step(0, '0,      1, 0, 0);

        // Stall holds a single entry for three cycles, then it pops.
        step(1, W'(5), 0, 0, 0);
        step(0, '0,    1, 0, 1);
        step(0, '0,    1, 0, 1);
        step(0, '0,    1, 0, 1);
        step(0, '0,    1, 0, 0);
        step(0, '0,    1, 0, 0);

        // Flush overriding stall.
        step(1, W'(7), 0, 0, 0);
        step(1, W'(8), 1, 1, 1);
        step(0, '0,    1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit lv;
            logic [W-1:0] d;
            if (n % 700 == 350) do_reset();
            if (pend) begin
                lv = 1'b1;
                d  = pend_d;
            end else begin
                lv = ($urandom_range(0, 9) < 7);
                d  = rnd();
            end
            step(lv, d, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 9) < 1));
        end
        repeat (4) step(0, '0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
